// File: rtl/unified_mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM: IF fetches and MEM
// loads/stores share the port, with a fixed two-cycle read latency and IF flush support.
module unified_mem_arbiter #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 32,
    parameter int MAX_ME_STREAK = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              me_req,
    input  logic              me_we,
    input  logic [ADDR_W-1:0] me_addr,
    input  logic [DATA_W-1:0] me_wdata,
    output logic              me_gnt,
    output logic              me_rvalid,
    output logic [DATA_W-1:0] me_rdata,
    output logic              stall_if,
    output logic              stall_me,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam logic [3:0] LP_MAX_STREAK = 4'(MAX_ME_STREAK);
    localparam logic       OWN_IF        = 1'b0;
    localparam logic       OWN_ME        = 1'b1;

    logic [3:0]        r_streak;
    logic              r_ram_en_p1;
    logic              r_ram_we_p1;
    logic [ADDR_W-1:0] r_ram_addr_p1;
    logic [DATA_W-1:0] r_ram_wdata_p1;
    logic              r_own_p1;
    logic              r_rd_p1;
    logic              r_vld_p2;
    logic              r_own_p2;

    logic w_streak_full;
    logic w_if_win;
    logic w_me_win;

    // MEM (older instruction) wins contention until IF has waited MAX_ME_STREAK grants
    assign w_streak_full = (r_streak == LP_MAX_STREAK);
    assign w_if_win      = if_req & (~me_req | w_streak_full);
    assign w_me_win      = me_req & ~w_if_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_streak <= 4'd0;
        end else if (w_if_win || !if_req) begin
            r_streak <= 4'd0;
        end else if (w_me_win && !w_streak_full) begin
            r_streak <= r_streak + 4'd1;
        end
    end

    // Cmd stage: winning command registered toward the RAM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_en_p1    <= 1'b0;
            r_ram_we_p1    <= 1'b0;
            r_ram_addr_p1  <= '0;
            r_ram_wdata_p1 <= '0;
            r_own_p1       <= OWN_IF;
            r_rd_p1        <= 1'b0;
        end else begin
            r_ram_en_p1 <= w_if_win | w_me_win;
            r_ram_we_p1 <= w_me_win & me_we;
            r_rd_p1     <= w_if_win | (w_me_win & ~me_we);
            if (w_me_win) begin
                r_ram_addr_p1  <= me_addr;
                r_ram_wdata_p1 <= me_wdata;
                r_own_p1       <= OWN_ME;
            end else if (w_if_win) begin
                r_ram_addr_p1 <= if_addr;
                r_own_p1      <= OWN_IF;
            end
        end
    end

    // Resp stage: a flush drops the IF read leaving the cmd stage; a fetch granted
    // in the flush cycle is the branch target and enters the cmd stage untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p2 <= 1'b0;
            r_own_p2 <= OWN_IF;
        end else begin
            r_vld_p2 <= r_rd_p1 & ~(if_flush & (r_own_p1 == OWN_IF));
            r_own_p2 <= r_own_p1;
        end
    end

    assign if_gnt    = w_if_win;
    assign me_gnt    = w_me_win;
    assign stall_if  = if_req & ~w_if_win;
    assign stall_me  = me_req & ~w_me_win;

    assign ram_en    = r_ram_en_p1;
    assign ram_we    = r_ram_we_p1;
    assign ram_addr  = r_ram_addr_p1;
    assign ram_wdata = r_ram_wdata_p1;

    assign if_rvalid = r_vld_p2 & (r_own_p2 == OWN_IF) & ~if_flush;
    assign me_rvalid = r_vld_p2 & (r_own_p2 == OWN_ME);
    assign if_rdata  = ram_rdata;
    assign me_rdata  = ram_rdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed cycle table, reset and flush sequences,
// and a random soak against a cycle model with a behavioural single-port RAM.
module tb_unified_mem_arbiter;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int MAXS = 3;
    localparam int NV   = 37;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, if_flush, me_req, me_we;
    logic [AW-1:0] if_addr, me_addr;
    logic [DW-1:0] me_wdata;
    logic          if_gnt, if_rvalid, me_gnt, me_rvalid, stall_if, stall_me;
    logic [DW-1:0] if_rdata, me_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          mem_init;
    logic [DW-1:0] mem [1024];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_ME_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .me_req(me_req), .me_we(me_we), .me_addr(me_addr), .me_wdata(me_wdata),
        .me_gnt(me_gnt), .me_rvalid(me_rvalid), .me_rdata(me_rdata),
        .stall_if(stall_if), .stall_me(stall_me),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    function automatic logic [31:0] memv(input int n);
        return 32'hC0DE_0000 | 32'(n);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= memv(i);
            ram_rdata <= '0;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    typedef struct {
        logic          ir;
        logic [AW-1:0] ia;
        logic          fl;
        logic          mr;
        logic          mw;
        logic [AW-1:0] ma;
        logic [DW-1:0] md;
        logic          eig;
        logic          emg;
        logic          een;
        logic          eirv;
        logic          emrv;
        logic [DW-1:0] ed;
    } vec_t;

    vec_t tv [NV];

    function automatic vec_t mk(input int ir, input int ia, input int fl, input int mr,
                                input int mw, input int ma, input logic [31:0] md,
                                input int eig, input int emg, input int een,
                                input int eirv, input int emrv, input logic [31:0] ed);
        vec_t v;
        v.ir = (ir != 0);  v.ia = AW'(ia);  v.fl = (fl != 0);
        v.mr = (mr != 0);  v.mw = (mw != 0); v.ma = AW'(ma); v.md = md;
        v.eig = (eig != 0); v.emg = (emg != 0); v.een = (een != 0);
        v.eirv = (eirv != 0); v.emrv = (emrv != 0); v.ed = ed;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // soak model state
    logic          c_rd, c_we, c_own, r_v, r_own;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wd, r_data_m;
    logic [3:0]    m_streak;
    logic [DW-1:0] ref_mem [16];
    logic          eig, emg, eirv, emrv, ir_pend, mr_pend;

    initial begin
        // IF stream 0..5
        tv[0]  = mk(1,0,0, 0,0,0,0, 1,0,0, 0,0, 0);
        tv[1]  = mk(1,1,0, 0,0,0,0, 1,0,1, 0,0, 0);
        tv[2]  = mk(1,2,0, 0,0,0,0, 1,0,1, 1,0, memv(0));
        tv[3]  = mk(1,3,0, 0,0,0,0, 1,0,1, 1,0, memv(1));
        tv[4]  = mk(1,4,0, 0,0,0,0, 1,0,1, 1,0, memv(2));
        tv[5]  = mk(1,5,0, 0,0,0,0, 1,0,1, 1,0, memv(3));
        tv[6]  = mk(0,0,0, 0,0,0,0, 0,0,1, 1,0, memv(4));
        tv[7]  = mk(0,0,0, 0,0,0,0, 0,0,0, 1,0, memv(5));
        tv[8]  = mk(0,0,0, 0,0,0,0, 0,0,0, 0,0, 0);
        // contention: ME,ME,ME,IF,ME,ME,ME,IF
        tv[9]  = mk(1,8,0, 1,0,32,0, 0,1,0, 0,0, 0);
        tv[10] = mk(1,8,0, 1,0,32,0, 0,1,1, 0,0, 0);
        tv[11] = mk(1,8,0, 1,0,32,0, 0,1,1, 0,1, memv(32));
        tv[12] = mk(1,8,0, 1,0,32,0, 1,0,1, 0,1, memv(32));
        tv[13] = mk(1,8,0, 1,0,32,0, 0,1,1, 0,1, memv(32));
        tv[14] = mk(1,8,0, 1,0,32,0, 0,1,1, 1,0, memv(8));
        tv[15] = mk(1,8,0, 1,0,32,0, 0,1,1, 0,1, memv(32));
        tv[16] = mk(1,8,0, 1,0,32,0, 1,0,1, 0,1, memv(32));
        tv[17] = mk(0,0,0, 0,0,0,0, 0,0,1, 0,1, memv(32));
        tv[18] = mk(0,0,0, 0,0,0,0, 0,0,0, 1,0, memv(8));
        tv[19] = mk(0,0,0, 0,0,0,0, 0,0,0, 0,0, 0);
        // store then fetch of the same word
        tv[20] = mk(0,0,0, 1,1,16,32'hDEADBEEF, 0,1,0, 0,0, 0);
        tv[21] = mk(1,16,0, 0,0,0,0, 1,0,1, 0,0, 0);
        tv[22] = mk(0,0,0, 0,0,0,0, 0,0,1, 0,0, 0);
        tv[23] = mk(0,0,0, 0,0,0,0, 0,0,0, 1,0, 32'hDEADBEEF);
        tv[24] = mk(0,0,0, 0,0,0,0, 0,0,0, 0,0, 0);
        // flush of an in-flight fetch, MEM load unaffected
        tv[25] = mk(1,3,0, 0,0,0,0, 1,0,0, 0,0, 0);
        tv[26] = mk(0,0,1, 1,0,5,0, 0,1,1, 0,0, 0);
        tv[27] = mk(0,0,0, 0,0,0,0, 0,0,1, 0,0, 0);
        tv[28] = mk(0,0,0, 0,0,0,0, 0,0,0, 0,1, memv(5));
        // fetch granted in the flush cycle survives
        tv[29] = mk(1,6,0, 0,0,0,0, 1,0,0, 0,0, 0);
        tv[30] = mk(1,7,1, 0,0,0,0, 1,0,1, 0,0, 0);
        tv[31] = mk(0,0,0, 0,0,0,0, 0,0,1, 0,0, 0);
        tv[32] = mk(0,0,0, 0,0,0,0, 0,0,0, 1,0, memv(7));
        // flush in the response cycle masks if_rvalid combinationally
        tv[33] = mk(1,9,0, 0,0,0,0, 1,0,0, 0,0, 0);
        tv[34] = mk(0,0,0, 0,0,0,0, 0,0,1, 0,0, 0);
        tv[35] = mk(0,0,1, 0,0,0,0, 0,0,0, 0,0, 0);
        tv[36] = mk(0,0,0, 0,0,0,0, 0,0,0, 0,0, 0);

        rst_n = 1'b0; mem_init = 1'b1;
        if_req = 0; if_addr = '0; if_flush = 0;
        me_req = 0; me_we = 0; me_addr = '0; me_wdata = '0;
        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        chk1("rst.ram_en", ram_en, 1'b0);
        chk1("rst.ram_we", ram_we, 1'b0);
        chk32("rst.ram_addr", 32'(ram_addr), 32'd0);
        chk1("rst.if_rvalid", if_rvalid, 1'b0);
        chk1("rst.me_rvalid", me_rvalid, 1'b0);
        chk1("rst.if_gnt", if_gnt, 1'b0);
        chk1("rst.stall_me", stall_me, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if_req = tv[i].ir; if_addr = tv[i].ia; if_flush = tv[i].fl;
            me_req = tv[i].mr; me_we = tv[i].mw; me_addr = tv[i].ma; me_wdata = tv[i].md;
            @(negedge clk);
            chk1($sformatf("v%0d.if_gnt", i), if_gnt, tv[i].eig);
            chk1($sformatf("v%0d.me_gnt", i), me_gnt, tv[i].emg);
            chk1($sformatf("v%0d.stall_if", i), stall_if, tv[i].ir & ~tv[i].eig);
            chk1($sformatf("v%0d.stall_me", i), stall_me, tv[i].mr & ~tv[i].emg);
            chk1($sformatf("v%0d.ram_en", i), ram_en, tv[i].een);
            chk1($sformatf("v%0d.if_rvalid", i), if_rvalid, tv[i].eirv);
            chk1($sformatf("v%0d.me_rvalid", i), me_rvalid, tv[i].emrv);
            if (tv[i].eirv) chk32($sformatf("v%0d.if_rdata", i), if_rdata, tv[i].ed);
            if (tv[i].emrv) chk32($sformatf("v%0d.me_rdata", i), me_rdata, tv[i].ed);
            @(posedge clk);
            #1;
        end

        // reset mid-cycle with a load in the cmd stage and the streak saturated
        if_req = 1; if_addr = 10'd1; if_flush = 0; me_req = 1; me_we = 0; me_addr = 10'd2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1($sformatf("rs.me_gnt%0d", k), me_gnt, 1'b1);
            @(posedge clk);
            #1;
        end
        chk1("rs.pre_ram_en", ram_en, 1'b1);
        chk1("rs.pre_me_rvalid", me_rvalid, 1'b1);
        chk32("rs.pre_me_rdata", me_rdata, memv(2));
        chk1("rs.pre_if_gnt", if_gnt, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("rs.ram_en", ram_en, 1'b0);
        chk1("rs.me_rvalid", me_rvalid, 1'b0);
        chk1("rs.if_rvalid", if_rvalid, 1'b0);
        chk32("rs.ram_addr", 32'(ram_addr), 32'd0);
        chk1("rs.me_gnt_in_rst", me_gnt, 1'b1);
        if_req = 0; me_req = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1($sformatf("rs.post_me_rvalid%0d", k), me_rvalid, 1'b0);
            chk1($sformatf("rs.post_if_rvalid%0d", k), if_rvalid, 1'b0);
            @(posedge clk);
            #1;
        end
        if_req = 1; me_req = 1;
        @(negedge clk);
        chk1("rs.contend_me_gnt", me_gnt, 1'b1);
        chk1("rs.contend_if_gnt", if_gnt, 1'b0);
        @(posedge clk);
        #1 if_req = 0; me_req = 0;
        repeat (3) @(posedge clk);
        #1;

        // random soak against the cycle model
        for (int i = 0; i < 16; i++) ref_mem[i] = memv(i);
        c_rd = 0; c_we = 0; c_own = 0; c_addr = '0; c_wd = '0;
        r_v = 0; r_own = 0; r_data_m = '0; m_streak = 4'd0;
        ir_pend = 0; mr_pend = 0;
        for (int n = 0; n < 400; n++) begin
            if (!ir_pend) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = AW'($urandom_range(0, 15));
            end
            if (!mr_pend) begin
                me_req   = ($urandom_range(0, 2) != 0);
                me_we    = ($urandom_range(0, 2) == 0);
                me_addr  = AW'($urandom_range(0, 15));
                me_wdata = $urandom;
            end
            if_flush = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            eig  = if_req & (~me_req | (m_streak == 4'(MAXS)));
            emg  = me_req & ~eig;
            eirv = r_v & ~r_own & ~if_flush;
            emrv = r_v & r_own;
            chk1($sformatf("s%0d.if_gnt", n), if_gnt, eig);
            chk1($sformatf("s%0d.me_gnt", n), me_gnt, emg);
            chk1($sformatf("s%0d.both_gnt", n), if_gnt & me_gnt, 1'b0);
            chk1($sformatf("s%0d.if_rvalid", n), if_rvalid, eirv);
            chk1($sformatf("s%0d.me_rvalid", n), me_rvalid, emrv);
            if (eirv) chk32($sformatf("s%0d.if_rdata", n), if_rdata, r_data_m);
            if (emrv) chk32($sformatf("s%0d.me_rdata", n), me_rdata, r_data_m);
            r_v   = c_rd & ~(if_flush & ~c_own);
            r_own = c_own;
            if (c_rd) r_data_m = ref_mem[c_addr[3:0]];
            if (c_we) ref_mem[c_addr[3:0]] = c_wd;
            c_own  = emg;
            c_rd   = eig | (emg & ~me_we);
            c_we   = emg & me_we;
            c_addr = emg ? me_addr : if_addr;
            c_wd   = me_wdata;
            if (eig || !if_req)                  m_streak = 4'd0;
            else if (emg && m_streak != 4'(MAXS)) m_streak = m_streak + 4'd1;
            ir_pend = if_req & ~eig;
            mr_pend = me_req & ~emg;
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
